tt_scanner: RTL and testbench
=============================

TT_SCANNER -- requirements
Module: tt_scanner

Interface
REQ-001 SHALL declare the clock `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL declare `rst_n`, input, 1 bit: synchronous active-low reset, sampled on the `clk` rising edge.
REQ-003 SHALL declare `start`, input, 1 bit: request a full truth-table scan; sampled only in IDLE.
REQ-004 SHALL declare `expect_tt`, input, 16 bits: expected truth table; bit i is the expected output for vector i.
REQ-005 SHALL declare `settle`, input, 4 bits: number of extra wait cycles after each new vector, before sampling.
REQ-006 SHALL declare `vec`, output, 4 bits: {a,b,c,d} drive to the 4-input function under test, with a as MSB.
REQ-007 SHALL declare `f_in`, input, 1 bit: the output of the function under test.
REQ-008 SHALL declare `busy`, output, 1 bit: high in SETTLE and SAMPLE.
REQ-009 SHALL declare `done`, output, 1 bit: one-cycle pulse in the DONE state.
REQ-010 SHALL declare `tt`, output, 16 bits: captured truth table.
REQ-011 SHALL declare `mismatch`, output, 16 bits: per-vector `tt` XOR expected.
REQ-012 SHALL declare `err_cnt`, output, 5 bits: count of mismatching vectors, range 0..16.
REQ-013 SHALL declare `pass`, output, 1 bit: high after a completed scan with `err_cnt` = 0.

Function
REQ-014 SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE, one-hot or binary.
REQ-015 In IDLE with `start`=1: SHALL latch `expect_tt` and `settle`; clear `tt`, `mismatch`, `err_cnt` and `pass`; set `vec`=0 and the wait counter to `settle`; go to SETTLE.
REQ-016 In SETTLE: if the wait counter is 0, SHALL go to SAMPLE; otherwise SHALL decrement the counter. `vec` is held stable.
REQ-017 In SAMPLE, SHALL set tt[vec] to `f_in`, set mismatch[vec] to `f_in` XOR latched expect[vec], and add that mismatch bit to `err_cnt`.
REQ-018 In SAMPLE with `vec`=15, SHALL go to DONE; otherwise SHALL increment `vec`, reload the counter with the latched `settle`, and go to SETTLE.
REQ-019 In DONE, SHALL assert `done`=1 for exactly one cycle and set `pass`=(`err_cnt`==0); then go to IDLE.
REQ-020 Latency SHALL be: each vector occupies `settle`+2 cycles, and DONE is entered 16×(`settle`+2) edges after the edge that sampled `start`.
REQ-021 `start` SHALL be ignored while `busy`=1 or in DONE; no queuing.
REQ-022 Changes to `expect_tt`/`settle` mid-scan SHALL have no effect; the latched copies are used.
REQ-023 `vec` SHALL NOT wrap: the scan ends at 15, and `vec` holds 15 through DONE and IDLE until the next `start`.
REQ-024 `tt`, `mismatch`, `err_cnt` and `pass` SHALL hold their values after DONE until the next accepted `start`.
REQ-025 `err_cnt` SHALL NOT overflow: 16 mismatches SHALL read 5'd16.

Reset
REQ-026 `rst_n`=0 at a rising edge SHALL force IDLE, `vec`=0, `busy`=0, `done`=0, `tt`=0, `mismatch`=0, `err_cnt`=0, `pass`=0, and the counter and latched copies to 0.
REQ-027 Reset mid-scan SHALL abort immediately, with no `done` pulse; the next scan requires a new `start`.
REQ-028 Reset SHALL take priority over `start` in the same cycle.

Structure
REQ-029 Package `tt_scan_pkg` SHALL hold the state encoding, NUM_VEC=16, VEC_W=4 and CNT_W=5.
REQ-030 The wait counter and vector counter SHALL be inline; no sub-module. The function under test SHALL be instantiated only in the bench, connected via `vec`/`f_in`.

Verification
REQ-031 f = ~c | ~d | (a & ~b), `expect_tt`=16'h7F77, `settle`=0 -> `done` 32 edges after `start`, `tt`=16'h7F77, `mismatch`=0, `err_cnt`=0, `pass`=1.
REQ-032 Same f, `expect_tt`=16'h7F7F -> `mismatch`=16'h0008, `err_cnt`=1, `pass`=0.
REQ-033 `f_in` tied 0, `expect_tt`=16'hFFFF -> `mismatch`=16'hFFFF, `err_cnt`=16, `pass`=0.
REQ-034 `settle`=3 -> each `vec` value held 5 cycles; `done` 80 edges after `start`; `settle` changed mid-scan has no effect.
REQ-035 `rst_n`=0 while `vec`=6 -> next edge IDLE with all outputs 0 and no `done`; `start` pulsed while `busy` -> ignored, and the single scan completes normally.

Source files
------------

// File: rtl/tt_scan_pkg.sv
// Shared definitions for the truth-table scanner.
// Contents:
//   NUM_VEC  number of input vectors of the 4-input function under test
//   VEC_W    width of the vector counter / vec output
//   CNT_W    width of the mismatch counter (must reach NUM_VEC)
//   state_e  scanner FSM state encoding
package tt_scan_pkg;

  localparam int unsigned NUM_VEC = 16;
  localparam int unsigned VEC_W   = 4;
  localparam int unsigned CNT_W   = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

endpackage

// File: rtl/tt_scanner.sv
// Truth-table scanner: walks a 4-input combinational function through all 16 input
// vectors, waits a programmable number of settle cycles per vector, samples the function
// output and compares the captured truth table against an expected one.
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      synchronous active-low reset
//   start      begin a scan (only honoured in idle)
//   expect_tt  expected truth table, bit i for vector i (latched at start)
//   settle     extra wait cycles per vector before sampling (latched at start)
//   vec        {a,b,c,d} drive to the function under test
//   f_in       output of the function under test
//   busy       high while settling or sampling
//   done       one-cycle pulse at the end of a scan
//   tt         captured truth table
//   mismatch   captured table XOR expected table
//   err_cnt    number of mismatching vectors (0..16)
//   pass       set after a completed scan with no mismatches
module tt_scanner
  import tt_scan_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_VEC-1:0] expect_tt,
  input  logic [3:0]         settle,
  output logic [VEC_W-1:0]   vec,
  input  logic               f_in,
  output logic               busy,
  output logic               done,
  output logic [NUM_VEC-1:0] tt,
  output logic [NUM_VEC-1:0] mismatch,
  output logic [CNT_W-1:0]   err_cnt,
  output logic               pass
);

  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         settle_q, settle_d;
  logic [NUM_VEC-1:0] exp_q, exp_d;
  logic [NUM_VEC-1:0] tt_q, tt_d;
  logic [NUM_VEC-1:0] mis_q, mis_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;
  logic               mis_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      vec_q    <= '0;
      cnt_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      tt_q     <= '0;
      mis_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      tt_q     <= tt_d;
      mis_q    <= mis_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    tt_d     = tt_q;
    mis_d    = mis_q;
    err_d    = err_q;
    pass_d   = pass_q;
    mis_bit  = f_in ^ exp_q[vec_q];

    case (state_q)
      StIdle: begin
        if (start) begin
          exp_d    = expect_tt;
          settle_d = settle;
          tt_d     = '0;
          mis_d    = '0;
          err_d    = '0;
          pass_d   = 1'b0;
          vec_d    = '0;
          cnt_d    = settle;
          state_d  = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StSample;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StSample: begin
        tt_d[vec_q]  = f_in;
        mis_d[vec_q] = mis_bit;
        // At most 16 increments into a 5-bit counter, so no saturation needed
        err_d        = err_q + CNT_W'(mis_bit);
        if (vec_q == VEC_W'(NUM_VEC - 1)) begin
          // vec stays at the last vector until the next accepted start
          state_d = StDone;
        end else begin
          vec_d   = vec_q + VEC_W'(1);
          cnt_d   = settle_q;
          state_d = StSettle;
        end
      end
      StDone: begin
        pass_d  = (err_q == '0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign vec      = vec_q;
  assign busy     = (state_q == StSettle) || (state_q == StSample);
  assign done     = (state_q == StDone);
  assign tt       = tt_q;
  assign mismatch = mis_q;
  assign err_cnt  = err_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_tt_scanner.sv
module tb_tt_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] expect_tt;
  logic [3:0]  settle;
  logic [3:0]  vec;
  logic        f_in;
  logic        busy;
  logic        done;
  logic [15:0] tt;
  logic [15:0] mismatch;
  logic [4:0]  err_cnt;
  logic        pass;

  // Function under test, expressed as its truth table indexed by {a,b,c,d}
  logic [15:0] fut;

  int n_checks = 0;
  int n_errors = 0;

  assign f_in = fut[vec];

  always #5 clk = ~clk;

  tt_scanner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expect_tt(expect_tt),
    .settle   (settle),
    .vec      (vec),
    .f_in     (f_in),
    .busy     (busy),
    .done     (done),
    .tt       (tt),
    .mismatch (mismatch),
    .err_cnt  (err_cnt),
    .pass     (pass)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  // f = ~c | ~d | (a & ~b)
  function automatic logic [15:0] spec_fn_tt();
    logic [15:0] r;
    logic [3:0]  v;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      v    = 4'(i);
      r[i] = ~v[1] | ~v[0] | (v[3] & ~v[2]);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full scan; outputs predicted from the function table and the expected table.
  // With perturb set, expect_tt/settle are scrambled and start is pulsed mid-scan.
  task automatic run_scan(input string name, input logic [15:0] exp_v, input logic [3:0] s,
                          input logic [15:0] fut_v, input bit perturb);
    int          per_vec;
    int          total;
    int          k;
    int          vec_bad;
    int          perturb_at;
    bit          seen;
    logic [15:0] ref_tt;
    logic [15:0] ref_mis;
    int          ref_err;

    per_vec    = int'(s) + 2;
    total      = 16 * per_vec;
    perturb_at = perturb ? int'($urandom_range(total - 2, 1)) : -1;
    ref_tt     = fut_v;
    ref_mis    = ref_tt ^ exp_v;
    ref_err    = $countones(ref_mis);

    fut       = fut_v;
    expect_tt = exp_v;
    settle    = s;
    start     = 1'b1;
    tick();
    start   = 1'b0;
    k       = 0;
    seen    = 1'b0;
    vec_bad = 0;
    while (!seen && k <= total + 4) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (!busy || int'(vec) != k / per_vec) vec_bad++;
        if (k == perturb_at) begin
          start     = 1'b1;
          expect_tt = 16'($urandom);
          settle    = 4'($urandom);
        end else begin
          start = 1'b0;
        end
        tick();
        k++;
      end
    end
    start = 1'b0;
    check({name, "/done_seen"}, 32'(seen), 32'd1);
    check({name, "/latency"}, k, total);
    check({name, "/vec_seq"}, vec_bad, 0);
    check({name, "/vec_in_done"}, 32'(vec), 32'd15);
    check({name, "/busy_in_done"}, 32'(busy), 32'd0);

    tick();
    check({name, "/done_pulse"}, 32'(done), 32'd0);
    check({name, "/tt"}, 32'(tt), 32'(ref_tt));
    check({name, "/mismatch"}, 32'(mismatch), 32'(ref_mis));
    check({name, "/err_cnt"}, 32'(err_cnt), ref_err);
    check({name, "/pass"}, 32'(pass), 32'(ref_err == 0));

    // Results hold through idle even with inputs wiggling
    expect_tt = 16'($urandom);
    settle    = 4'($urandom);
    fut       = 16'($urandom);
    repeat (3) tick();
    check({name, "/hold_tt"}, 32'(tt), 32'(ref_tt));
    check({name, "/hold_err"}, 32'(err_cnt), ref_err);
    check({name, "/hold_vec"}, 32'(vec), 32'd15);
    check({name, "/hold_idle"}, 32'({busy, done}), 32'd0);
  endtask

  task automatic check_zero(input string name);
    check({name, "/busy"}, 32'(busy), 32'd0);
    check({name, "/done"}, 32'(done), 32'd0);
    check({name, "/vec"}, 32'(vec), 32'd0);
    check({name, "/tt"}, 32'(tt), 32'd0);
    check({name, "/mismatch"}, 32'(mismatch), 32'd0);
    check({name, "/err_cnt"}, 32'(err_cnt), 32'd0);
    check({name, "/pass"}, 32'(pass), 32'd0);
  endtask

  initial begin
    int   guard;
    int   done_hits;
    logic [15:0] rexp;
    logic [15:0] rfut;

    rst_n     = 1'b0;
    start     = 1'b0;
    expect_tt = '0;
    settle    = '0;
    fut       = '0;
    repeat (2) tick();
    check_zero("reset");
    rst_n = 1'b1;
    tick();

    run_scan("match", 16'h7F77, 4'd0, spec_fn_tt(), 1'b0);
    run_scan("one_err", 16'h7F7F, 4'd0, spec_fn_tt(), 1'b0);
    run_scan("all_err", 16'hFFFF, 4'd0, 16'h0000, 1'b0);
    run_scan("settle3", 16'h7F77, 4'd3, spec_fn_tt(), 1'b1);

    // Reset mid-scan at vec 6
    fut       = spec_fn_tt();
    expect_tt = 16'h0000;
    settle    = 4'd2;
    start     = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (vec != 4'd6 && guard < 100) begin
      tick();
      guard++;
    end
    check("abort/reach_vec6", 32'(vec), 32'd6);
    rst_n = 1'b0;
    tick();
    check_zero("abort");
    rst_n     = 1'b1;
    done_hits = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (done || busy) done_hits++;
    end
    check("abort/stays_idle", done_hits, 0);

    // Reset wins over a simultaneous start
    rst_n = 1'b0;
    start = 1'b1;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    check_zero("rst_prio");
    tick();
    check("rst_prio/no_scan", 32'(busy), 32'd0);

    for (int n = 0; n < 8; n++) begin
      rexp = 16'($urandom);
      rfut = (n == 0) ? rexp : 16'($urandom);
      run_scan($sformatf("rand%0d", n), rexp, 4'($urandom), rfut, n[0]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
